// File: rtl/pair_code_pkg.sv
// Shared types and helpers for the pair-coded stream decoder.
// Each pair carries x = ~c ^ (a&b) and y = a&b.
package pair_code_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2
   } state_e;

   // x ^ y cancels the a&b term and leaves ~c.
   function automatic logic decode_c(input logic x, input logic y);
      return ~(x ^ y);
   endfunction

endpackage

// File: rtl/pair_stream_decoder_if.sv
// Pair input stream and decoded frame output stream of the decoder.
// Handshake: a beat moves on a rising clk edge only when valid && ready are both high;
// the sender holds its payload while valid is high and ready is low.
interface pair_stream_decoder_if #(
   parameter int NBITS = 8
);
   logic             in_valid;
   logic             in_sof;
   logic             in_x;
   logic             in_y;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [NBITS-1:0] out_c;
   logic [NBITS-1:0] out_and;
   logic             err_restart;

   modport master (
      output in_valid, in_sof, in_x, in_y, out_ready,
      input  in_ready, out_valid, out_c, out_and, err_restart
   );

   modport slave (
      input  in_valid, in_sof, in_x, in_y, out_ready,
      output in_ready, out_valid, out_c, out_and, err_restart
   );
endinterface

// File: rtl/pair_bit_decode.sv
// Combinational decode of one coded pair into its c bit and a&b bit.
module pair_bit_decode
   import pair_code_pkg::*;
(
   input  logic x,
   input  logic y,
   output logic c,
   output logic and_bit
);
   assign c       = decode_c(x, y);
   assign and_bit = y;
endmodule

// File: rtl/pair_stream_decoder.sv
// Collects NBITS decoded pairs (LSB first) into a frame and holds it until the consumer takes it.
// An early in_sof aborts the partial frame and restarts collection with a one-cycle err_restart.
module pair_stream_decoder
   import pair_code_pkg::*;
#(
   parameter int NBITS = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   pair_stream_decoder_if.slave    bus,
   output state_e                  state
);
   localparam int            CW   = $clog2(NBITS + 1);
   localparam logic [CW-1:0] LAST = CW'(NBITS - 1);
   localparam logic [CW-1:0] FULL = CW'(NBITS);

   logic [CW-1:0]    count;
   logic [NBITS-1:0] c_reg;
   logic [NBITS-1:0] and_reg;
   logic [NBITS-1:0] bit_mask;
   logic             dec_c;
   logic             dec_and;
   logic             in_ready_r;
   logic             out_valid_r;
   logic             err_r;
   logic             take;

   pair_bit_decode u_decode (
      .x       (bus.in_x),
      .y       (bus.in_y),
      .c       (dec_c),
      .and_bit (dec_and)
   );

   assign take     = bus.in_valid && in_ready_r;
   assign bit_mask = {{(NBITS-1){1'b0}}, 1'b1} << count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         count       <= '0;
         c_reg       <= '0;
         and_reg     <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         err_r <= 1'b0;
         unique case (state)
            IDLE: begin
               if (take && bus.in_sof) begin
                  c_reg   <= {{(NBITS-1){1'b0}}, dec_c};
                  and_reg <= {{(NBITS-1){1'b0}}, dec_and};
                  count   <= CW'(1);
                  state   <= COLLECT;
               end
            end
            COLLECT: begin
               if (take) begin
                  if (bus.in_sof) begin
                     c_reg   <= {{(NBITS-1){1'b0}}, dec_c};
                     and_reg <= {{(NBITS-1){1'b0}}, dec_and};
                     count   <= CW'(1);
                     err_r   <= 1'b1;
                  end else begin
                     c_reg   <= (c_reg & ~bit_mask) | (bit_mask & {NBITS{dec_c}});
                     and_reg <= (and_reg & ~bit_mask) | (bit_mask & {NBITS{dec_and}});
                     count   <= count + CW'(1);
                     if (count == LAST) begin
                        state       <= HOLD;
                        in_ready_r  <= 1'b0;
                        out_valid_r <= 1'b1;
                     end
                  end
               end
            end
            HOLD: begin
               // Release takes a whole cycle so a new frame never starts on the handshake edge.
               if (bus.out_ready) begin
                  state       <= IDLE;
                  count       <= '0;
                  c_reg       <= '0;
                  and_reg     <= '0;
                  in_ready_r  <= 1'b1;
                  out_valid_r <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               count       <= '0;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   // Shift registers hold partial frames while collecting; mask them off the bus until valid.
   assign bus.in_ready    = in_ready_r;
   assign bus.out_valid   = out_valid_r;
   assign bus.out_c       = c_reg & {NBITS{out_valid_r}};
   assign bus.out_and     = and_reg & {NBITS{out_valid_r}};
   assign bus.err_restart = err_r;

   // count only reaches FULL while holding a complete frame.
   logic unused_full;
   assign unused_full = (count == FULL);

endmodule

// File: tb/tb_pair_stream_decoder.sv
// Bench for pair_stream_decoder: frame vector table, corner sequences and random traffic vs a model.
module tb_pair_stream_decoder;
   import pair_code_pkg::*;

   localparam int NBITS = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   pair_stream_decoder_if #(.NBITS(NBITS)) bus ();
   state_e dbg_state;

   pair_stream_decoder #(.NBITS(NBITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .state (dbg_state)
   );

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_pass   = 0;
   int err_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   logic [1:0]         m_bits[$];   // {c, and} per collected pair, index = bit position
   logic [2*NBITS-1:0] exp_q[$];    // completed frames awaiting consumption
   bit                 m_collect = 0;
   bit                 m_hold = 0;
   bit                 m_err = 0;
   logic [NBITS-1:0]   m_fc = '0;
   logic [NBITS-1:0]   m_fa = '0;

   function automatic void model_reset();
      m_bits.delete();
      exp_q.delete();
      m_collect = 0;
      m_hold = 0;
      m_err = 0;
      m_fc = '0;
      m_fa = '0;
   endfunction

   function automatic void model_step(input bit v, input bit sof, input bit c, input bit a,
                                      input bit ordy);
      m_err = 0;
      if (m_hold) begin
         if (ordy) begin
            m_hold = 0;
            m_fc = '0;
            m_fa = '0;
         end
      end else if (v) begin
         if (sof) begin
            if (m_collect) m_err = 1;
            m_bits.delete();
            m_bits.push_back({c, a});
            m_collect = 1;
         end else if (m_collect) begin
            m_bits.push_back({c, a});
         end
         if (m_bits.size() == NBITS) begin
            for (int i = 0; i < NBITS; i++) begin
               m_fc[i] = m_bits[i][1];
               m_fa[i] = m_bits[i][0];
            end
            exp_q.push_back({m_fc, m_fa});
            m_bits.delete();
            m_collect = 0;
            m_hold = 1;
         end
      end
   endfunction

   // ---------------- driver ----------------
   // One clock: apply inputs, let the edge happen, then compare every output with the model.
   task automatic cycle(input bit v, input bit sof, input bit c, input bit a, input bit ordy);
      bit               got;
      logic [2*NBITS-1:0] got_val;
      bus.in_valid  = v;
      bus.in_sof    = sof;
      bus.in_x      = ~c ^ a;
      bus.in_y      = a;
      bus.out_ready = ordy;
      got     = bus.out_valid && ordy;
      got_val = {bus.out_c, bus.out_and};
      @(posedge clk);
      model_step(v, sof, c, a, ordy);
      if (got) begin
         if (exp_q.size() == 0) chk("frame_unexpected", 32'(got_val), 32'hFFFF_FFFF);
         else chk("frame", 32'(got_val), 32'(exp_q.pop_front()));
      end
      #1;
      chk("in_ready", 32'(bus.in_ready), 32'(!m_hold));
      chk("out_valid", 32'(bus.out_valid), 32'(m_hold));
      chk("out_c", 32'(bus.out_c), 32'(m_fc));
      chk("out_and", 32'(bus.out_and), 32'(m_fa));
      chk("err_restart", 32'(bus.err_restart), 32'(m_err));
      if (bus.err_restart) err_seen++;
   endtask

   task automatic do_reset();
      bus.in_valid  = 1'b0;
      bus.in_sof    = 1'b0;
      bus.in_x      = 1'b0;
      bus.in_y      = 1'b0;
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_c", 32'(bus.out_c), 32'd0);
      chk("rst_out_and", 32'(bus.out_and), 32'd0);
      chk("rst_err", 32'(bus.err_restart), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- frame vector table ----------------
   typedef struct {
      logic [NBITS-1:0] c;
      logic [NBITS-1:0] andb;
      int               stall_after;  // stall after this many pairs (0 = none)
      int               stall_len;
      int               restart_at;   // pair number carrying the early sof (0 = none)
      int               hold;         // cycles out_ready stays low in HOLD
      logic [NBITS-1:0] exp_c;
      logic [NBITS-1:0] exp_and;
      int               exp_lat;      // cycles from sof pair to out_valid visible
      int               exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic send_frame(input vec_t r, input string tag);
      int lat;
      err_seen = 0;
      for (int i = 0; i < r.restart_at - 1; i++)
         cycle(1'b1, i == 0, 1'($urandom), 1'($urandom), 1'b0);
      lat = 0;
      for (int i = 0; i < NBITS; i++) begin
         cycle(1'b1, i == 0, r.c[i], r.andb[i], 1'b0);
         lat++;
         if (i == r.stall_after - 1)
            for (int s = 0; s < r.stall_len; s++) begin
               cycle(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'b0);
               lat++;
            end
      end
      for (int g = 0; g < 20 && !bus.out_valid; g++) begin
         cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(r.exp_lat));
      chk({tag, "_c"}, 32'(bus.out_c), 32'(r.exp_c));
      chk({tag, "_and"}, 32'(bus.out_and), 32'(r.exp_and));
      for (int h = 0; h < r.hold; h++) begin
         cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
         chk({tag, "_hold_c"}, 32'(bus.out_c), 32'(r.exp_c));
         chk({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk({tag, "_released"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_err_count"}, 32'(err_seen), 32'(r.exp_err));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      vecs[0] = '{8'hA5, 8'h0F, 0, 0, 0, 0, 8'hA5, 8'h0F, 8, 0};
      vecs[1] = '{8'hA5, 8'h0F, 4, 3, 0, 0, 8'hA5, 8'h0F, 11, 0};
      vecs[2] = '{8'hA5, 8'h0F, 0, 0, 0, 5, 8'hA5, 8'h0F, 8, 0};
      vecs[3] = '{8'h3C, 8'hF0, 0, 0, 5, 0, 8'h3C, 8'hF0, 8, 1};
      vecs[4] = '{8'hFF, 8'h00, 2, 1, 0, 2, 8'hFF, 8'h00, 9, 0};
      vecs[5] = '{8'h00, 8'hFF, 7, 4, 3, 1, 8'h00, 8'hFF, 12, 1};

      #1;
      do_reset();

      // pairs without sof while idle are dropped
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'b1);
      chk("idle_discard", 32'(bus.out_valid), 32'd0);

      for (int k = 0; k < 6; k++) send_frame(vecs[k], $sformatf("vec%0d", k));

      // reset in the middle of collection drops the partial frame
      for (int i = 0; i < 3; i++) cycle(1'b1, i == 0, 1'b1, 1'b0, 1'b0);
      do_reset();
      chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
      send_frame(vecs[0], "after_rst");

      // reset while holding a finished frame
      for (int i = 0; i < NBITS; i++) cycle(1'b1, i == 0, 1'b1, 1'b1, 1'b0);
      do_reset();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("hold_rst_no_valid", 32'(bus.out_valid), 32'd0);

      // random traffic against the model
      for (int i = 0; i < 1500; i++)
         cycle($urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0,
               1'($urandom), 1'($urandom), $urandom_range(0, 1) == 1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pair_stream_decoder.md
PAIR_STREAM_DECODER -- requirements
Module: pair_stream_decoder

Interface
REQ-001 SHALL have parameter NBITS, default 8, giving the number of symbol bits per frame (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1: a coded pair is present on in_x/in_y.
REQ-005 SHALL have port in_sof, input, 1: qualified by in_valid, marks the first pair of a frame.
REQ-006 SHALL have port in_x, input, 1: coded bit x = ~c ^ (a & b).
REQ-007 SHALL have port in_y, input, 1: coded bit y = a & b.
REQ-008 SHALL have port in_ready, output, 1: the decoder accepts a pair this cycle.
REQ-009 SHALL have port out_valid, output, 1: a decoded frame is present on out_c/out_and.
REQ-010 SHALL have port out_ready, input, 1: the consumer accepts the frame.
REQ-011 SHALL have port out_c, output, NBITS: recovered c bits.
REQ-012 SHALL have port out_and, output, NBITS: recovered a&b bits.
REQ-013 SHALL have port err_restart, output, 1: one-cycle pulse when a frame is aborted by an early in_sof.

Function
REQ-014 SHALL transfer a pair only when in_valid && in_ready, and a frame only when out_valid && out_ready.
REQ-015 SHALL decode each accepted pair as c = ~(in_x ^ in_y) and and_bit = in_y.
REQ-016 SHALL implement FSM states IDLE, COLLECT, HOLD.
REQ-017 IDLE: in_ready = 1; an accepted pair with in_sof = 1 stores bit 0, sets count = 1 and moves to COLLECT; an accepted pair with in_sof = 0 is discarded.
REQ-018 COLLECT: in_ready = 1; each accepted pair with in_sof = 0 is stored at bit index count (LSB first) and count increments.
REQ-019 COLLECT: when the pair at index NBITS-1 is accepted, the FSM SHALL move to HOLD with out_valid = 1 in the next cycle (latency one cycle after the last pair).
REQ-020 COLLECT: an accepted pair with in_sof = 1 SHALL discard the partial frame, pulse err_restart in the next cycle, store the pair as bit 0 and set count = 1.
REQ-021 HOLD: in_ready = 0; out_valid = 1; out_c/out_and stay stable until the frame handshake.
REQ-022 HOLD with out_ready = 1 SHALL return to IDLE with out_valid = 0 in the next cycle; a new frame SHALL not be accepted in the same cycle.
REQ-023 No pair is accepted and no state changes while in_valid = 0 (stalls of any length are legal in COLLECT).
REQ-024 count SHALL be $clog2(NBITS+1) bits wide and never exceed NBITS.
REQ-025 out_c/out_and SHALL be zero whenever out_valid = 0.

Reset
REQ-026 rst_n = 0 SHALL, asynchronously, force state IDLE, count 0, shift registers 0, out_valid 0, err_restart 0; in_ready is 1 from the first cycle after rst_n deasserts.
REQ-027 Reset asserted in COLLECT or HOLD SHALL drop the frame, with no out_valid and no err_restart.

Structure
REQ-028 The state enum (IDLE, COLLECT, HOLD) SHALL live in shared package pair_code_pkg, along with function decode_c(x, y).
REQ-029 The pair decode (REQ-015) SHALL be a combinational sub-module pair_bit_decode; the FSM, counter and registers stay in the top module.

Verification
REQ-030 NBITS=8, frame c=8'hA5 with a&b=8'h0F, no stalls -> out_valid one cycle after the 8th pair, out_c=8'hA5, out_and=8'h0F.
REQ-031 Same frame with in_valid low for 3 cycles after pair 4 -> identical output, latency extended by exactly 3 cycles.
REQ-032 out_ready held 0 for 5 cycles in HOLD -> out_valid and data stable, in_ready=0, pairs offered then are ignored; out_ready=1 -> IDLE next cycle.
REQ-033 in_sof re-asserted at pair 5 -> err_restart pulse for one cycle, then the new 8-pair frame decodes correctly.
REQ-034 rst_n pulsed low mid-COLLECT after 3 pairs -> all outputs 0 immediately; next full frame decodes correctly.
REQ-035 Pairs without in_sof while IDLE -> discarded, no out_valid.
